// File: rtl/muldiv_unit_if.sv
// Operation/result bundle between the Execute stage and muldiv_unit.
// The master offers ops and reads results; the unit is the slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             done;
    logic             div_by_zero;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, in_valid, op, rs, rt,
        input  in_ready, out_valid, out_data, done, div_by_zero,
        input  busy, hi, lo
    );

    modport slave (
        input  flush, in_valid, op, rs, rt,
        output in_ready, out_valid, out_data, done, div_by_zero,
        output busy, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO pair.
// One step per cycle; results committed only in FIX, so flush is clean.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clock,
    input logic          reset_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_dz;
    logic               r_neg;
    logic               r_rneg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_done;
    logic               r_dz_out;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic               w_rt_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dz_out;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

    assign w_accept  = bus.in_valid & bus.in_ready & ~bus.flush;
    assign w_is_mul  = (bus.op[2:1] == 2'b00);
    assign w_is_div  = (bus.op[2:1] == 2'b01);
    assign w_signed  = ~bus.op[0];
    assign w_rs_neg  = w_signed & bus.rs[WIDTH-1];
    assign w_rt_neg  = w_signed & bus.rt[WIDTH-1];
    assign w_rs_mag  = w_rs_neg ? -bus.rs : bus.rs;
    assign w_rt_mag  = w_rt_neg ? -bus.rt : bus.rt;
    assign w_rt_zero = (bus.rt == '0);
    assign w_last    = (r_cnt == LAST);

    // Multiply: add into upper half, then shift the whole accumulator right.
    assign w_addend = r_opb[0] ? r_opa : '0;
    assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // Divide: upper half is the partial remainder, lower half the quotient.
    assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opa};
    assign w_ge    = ~w_diff[WIDTH];

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_rneg ? -r_acc[2*WIDTH-1:WIDTH]
                           : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (1'b1)
                        w_is_mul: w_state_nxt = S_MUL;
                        w_is_div: w_state_nxt = w_rt_zero ? S_FIX : S_DIV;
                        default:  w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_dz        <= 1'b0;
            r_neg       <= 1'b0;
            r_rneg      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_dz_out    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_dz_out    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        unique case (bus.op)
                            3'b000, 3'b001: begin
                                r_acc    <= '0;
                                r_opa    <= w_rs_mag;
                                r_opb    <= w_rt_mag;
                                r_neg    <= w_rs_neg ^ w_rt_neg;
                                r_rneg   <= 1'b0;
                                r_is_div <= 1'b0;
                                r_dz     <= 1'b0;
                            end
                            3'b010, 3'b011: begin
                                // Zero divisor keeps raw rs for the HI commit.
                                r_acc    <= {{WIDTH{1'b0}},
                                             w_rt_zero ? bus.rs : w_rs_mag};
                                r_opa    <= w_rt_mag;
                                r_neg    <= w_rs_neg ^ w_rt_neg;
                                r_rneg   <= w_rs_neg;
                                r_is_div <= 1'b1;
                                r_dz     <= w_rt_zero;
                            end
                            3'b100: begin
                                r_out_data  <= r_hi;
                                r_out_valid <= 1'b1;
                            end
                            3'b101: begin
                                r_out_data  <= r_lo;
                                r_out_valid <= 1'b1;
                            end
                            3'b110: r_hi <= bus.rs;
                            3'b111: r_lo <= bus.rs;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= {w_msum, r_acc[WIDTH-1:1]};
                    r_opb <= r_opb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= {w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0],
                              r_acc[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        r_done   <= 1'b1;
                        r_dz_out <= r_dz;
                        if (r_dz) begin
                            r_lo <= '1;
                            r_hi <= r_acc[WIDTH-1:0];
                        end else if (r_is_div) begin
                            r_lo <= w_quo;
                            r_hi <= w_rem;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: WIDTH=32 instance plus a WIDTH=8 one.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   k;
    int   nd;

    muldiv_unit_if #(.WIDTH(32)) b32 ();
    muldiv_unit_if #(.WIDTH(8))  b8 ();

    muldiv_unit #(.WIDTH(32)) u32 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (b32)
    );

    muldiv_unit #(.WIDTH(8)) u8 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (b8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue32(input logic [2:0] op, input logic [31:0] rs,
                           input logic [31:0] rt);
        b32.op       = op;
        b32.rs       = rs;
        b32.rt       = rt;
        b32.in_valid = 1'b1;
        @(negedge clk);
        b32.in_valid = 1'b0;
    endtask

    task automatic wait_done32(output int cyc);
        cyc = 0;
        while (b32.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (b8.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        b32.flush = 1'b0; b32.in_valid = 1'b0;
        b32.op = 3'd0; b32.rs = '0; b32.rt = '0;
        b8.flush = 1'b0; b8.in_valid = 1'b0;
        b8.op = 3'd0; b8.rs = '0; b8.rt = '0;

        @(negedge clk);
        check("rst_hilo", {b32.hi, b32.lo}, 64'h0);
        check("rst_outdata", b32.out_data, 64'h0);
        check("rst_flags", {b32.out_valid, b32.done, b32.div_by_zero,
                            b32.busy, b32.in_ready}, 64'b00001);
        rst_n = 1'b1;
        @(negedge clk);

        issue32(3'b000, 32'hFFFF_FFFF, 32'h3);
        check("mult_busy", b32.busy, 64'h1);
        wait_done32(k);
        check("mult_latency", k, 64'd33);
        check("mult_lo", b32.lo, 64'hFFFF_FFFD);
        check("mult_hi", b32.hi, 64'hFFFF_FFFF);
        check("mult_dz", b32.div_by_zero, 64'h0);
        issue32(3'b101, 32'h0, 32'h0);
        check("mflo_valid", b32.out_valid, 64'h1);
        check("mflo_data", b32.out_data, 64'hFFFF_FFFD);
        issue32(3'b100, 32'h0, 32'h0);
        check("mfhi_data", b32.out_data, 64'hFFFF_FFFF);

        issue32(3'b001, 32'hFFFF_FFFF, 32'h3);
        wait_done32(k);
        check("multu_hilo", {b32.hi, b32.lo}, 64'h0000_0002_FFFF_FFFD);

        issue32(3'b010, 32'hFFFF_FFF9, 32'h2);
        wait_done32(k);
        check("div_latency", k, 64'd33);
        check("div_lo", b32.lo, 64'hFFFF_FFFD);
        check("div_hi", b32.hi, 64'hFFFF_FFFF);

        issue32(3'b011, 32'hFFFF_FFF9, 32'h2);
        wait_done32(k);
        check("divu_hilo", {b32.hi, b32.lo}, 64'h0000_0001_7FFF_FFFC);

        issue32(3'b010, 32'h1234, 32'h0);
        wait_done32(k);
        check("dz_latency", k, 64'd1);
        check("dz_flag", b32.div_by_zero, 64'h1);
        check("dz_hilo", {b32.hi, b32.lo}, 64'h0000_1234_FFFF_FFFF);

        issue32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done32(k);
        check("ovf_hilo", {b32.hi, b32.lo}, 64'h0000_0000_8000_0000);
        check("ovf_dz", b32.div_by_zero, 64'h0);

        issue32(3'b110, 32'hA5A5_A5A5, 32'h0);
        check("mthi_hi", b32.hi, 64'hA5A5_A5A5);
        check("mthi_pulses", {b32.out_valid, b32.done}, 64'h0);
        issue32(3'b100, 32'h0, 32'h0);
        check("mthi_mfhi", b32.out_data, 64'hA5A5_A5A5);

        issue32(3'b000, 32'd5, 32'd7);
        check("hold_ready", b32.in_ready, 64'h0);
        b32.op = 3'b101;
        b32.in_valid = 1'b1;
        k = 0;
        while (b32.out_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        b32.in_valid = 1'b0;
        check("hold_latency", k, 64'd34);
        check("hold_data", b32.out_data, 64'd35);

        issue32(3'b010, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        b32.flush = 1'b1;
        @(negedge clk);
        b32.flush = 1'b0;
        check("flush_ready", {b32.in_ready, b32.busy}, 64'b10);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (b32.done === 1'b1) nd++;
        end
        check("flush_nodone", nd, 64'd0);
        check("flush_hilo", {b32.hi, b32.lo}, 64'd35);

        b32.op = 3'b111;
        b32.rs = 32'hDEAD_BEEF;
        b32.in_valid = 1'b1;
        b32.flush = 1'b1;
        @(negedge clk);
        b32.in_valid = 1'b0;
        b32.flush = 1'b0;
        check("idle_flush_lo", b32.lo, 64'd35);

        issue32(3'b000, 32'd3, 32'd4);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hilo", {b32.hi, b32.lo}, 64'h0);
        check("arst_outdata", b32.out_data, 64'h0);
        check("arst_flags", {b32.out_valid, b32.done, b32.div_by_zero,
                             b32.busy, b32.in_ready}, 64'b00001);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        b8.op = 3'b000;
        b8.rs = 8'h80;
        b8.rt = 8'h80;
        b8.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        wait_done8(k);
        check("w8_latency", k, 64'd9);
        check("w8_hilo", {b8.hi, b8.lo}, 64'h4000);

        b8.op = 3'b010;
        b8.rs = 8'h80;
        b8.rt = 8'hFF;
        b8.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        wait_done8(k);
        check("w8_ovf_hilo", {b8.hi, b8.lo}, 64'h0080);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
